// File: rtl/shm_request_arbiter.sv
// Round-robin arbiter serialising toggle-style shared-memory requests from
// PROC_CNT processors into a single DMA command stream with a BUSY watchdog.
// Ports: clock, reset_n (sync, active-low);
//   per-proc trigger/action/ptr/copy_start/copy_length in, ack/ptr_out/err out;
//   req_valid/req_proc/req_action/req_ptr/req_copy_* out with req_ready in;
//   eng_done/eng_ptr completion in; busy out.
module shm_request_arbiter #(
  parameter int PROC_CNT = 4,
  parameter int TIMEOUT  = 64,
  parameter int SIZE     = 4,
  parameter int PROCSIZE = 4,
  localparam int PW = (PROC_CNT > 1) ? $clog2(PROC_CNT) : 1,
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                trigger     [0:PROC_CNT-1],
  input  logic [1:0]          action      [0:PROC_CNT-1],
  input  logic [SIZE-1:0]     ptr         [0:PROC_CNT-1],
  input  logic [PROCSIZE-1:0] copy_start  [0:PROC_CNT-1],
  input  logic [PROCSIZE-1:0] copy_length [0:PROC_CNT-1],
  output logic                ack         [0:PROC_CNT-1],
  output logic [SIZE-1:0]     ptr_out     [0:PROC_CNT-1],
  output logic                err         [0:PROC_CNT-1],
  output logic                req_valid,
  output logic [PW-1:0]       req_proc,
  output logic [1:0]          req_action,
  output logic [SIZE-1:0]     req_ptr,
  output logic [PROCSIZE-1:0] req_copy_start,
  output logic [PROCSIZE-1:0] req_copy_length,
  input  logic                req_ready,
  input  logic                eng_done,
  input  logic [SIZE-1:0]     eng_ptr,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [1:0] ACT_WRITE = 2'd1;
  localparam logic [1:0] ACT_BAD   = 2'd3;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic          trig_q;
  logic          inv_q;
  logic [WW-1:0] wd;

  logic          found;
  logic [PW-1:0] gnt;
  logic [PW-1:0] nxt;

  // First pending index at or after rr_ptr; scanning downward lets the
  // closest candidate overwrite the farther ones.
  always_comb begin : grant_search
    int            j;
    logic [PW-1:0] jj;
    found = 1'b0;
    gnt   = '0;
    j     = 0;
    jj    = '0;
    for (int k = PROC_CNT - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= PROC_CNT) j = j - PROC_CNT;
      jj = PW'(j);
      if (trigger[jj] != ack[jj]) begin
        found = 1'b1;
        gnt   = jj;
      end
    end
  end

  assign nxt = (req_proc == PW'(PROC_CNT - 1)) ? '0 : req_proc + 1'b1;

  // req_* double as the grant-time latches, so they hold steady
  // through ISSUE regardless of what the processor does meanwhile.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      trig_q          <= 1'b0;
      inv_q           <= 1'b0;
      wd              <= '0;
      busy            <= 1'b0;
      req_valid       <= 1'b0;
      req_proc        <= '0;
      req_action      <= '0;
      req_ptr         <= '0;
      req_copy_start  <= '0;
      req_copy_length <= '0;
      for (int i = 0; i < PROC_CNT; i++) begin
        ack[i]     <= 1'b0;
        err[i]     <= 1'b0;
        ptr_out[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (inv_q) begin
            // invalid action: retire one cycle after grant, no command
            inv_q         <= 1'b0;
            ack[req_proc] <= trig_q;
            err[req_proc] <= 1'b1;
            rr_ptr        <= nxt;
          end else if (found) begin
            req_proc        <= gnt;
            trig_q          <= trigger[gnt];
            req_action      <= action[gnt];
            req_ptr         <= ptr[gnt];
            req_copy_start  <= copy_start[gnt];
            req_copy_length <= copy_length[gnt];
            if (action[gnt] == ACT_BAD) begin
              inv_q <= 1'b1;
            end else begin
              state     <= ISSUE;
              req_valid <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (req_ready) begin
            state     <= BUSY;
            req_valid <= 1'b0;
            wd        <= '0;
          end
        end
        BUSY: begin
          if (eng_done) begin
            state         <= IDLE;
            busy          <= 1'b0;
            ack[req_proc] <= trig_q;
            rr_ptr        <= nxt;
            if (req_action == ACT_WRITE) ptr_out[req_proc] <= eng_ptr;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            state         <= IDLE;
            busy          <= 1'b0;
            ack[req_proc] <= trig_q;
            err[req_proc] <= 1'b1;
            rr_ptr        <= nxt;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shm_request_arbiter.md
SHM_REQUEST_ARBITER -- requirements
Module: shm_request_arbiter

Interface
REQ-001 Parameters SHALL be: PROC_CNT, default 4, number of requesting processors; TIMEOUT, default 64, watchdog limit in cycles; SIZE, default 4, shared-memory address width; PROCSIZE, default 4, processor-memory address width.
REQ-002 clock  in  1  single clock; all logic on its rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 trigger[0:PROC_CNT-1]  in  1 each  toggle-style request; a request is pending while trigger[i] != ack[i].
REQ-005 action[0:PROC_CNT-1]  in  2 each  0=READ, 1=WRITE, 2=FREE, 3=invalid.
REQ-006 ptr[0:PROC_CNT-1]  in  SIZE each  shared-memory pointer.
REQ-007 copy_start[0:PROC_CNT-1], copy_length[0:PROC_CNT-1]  in  PROCSIZE each  processor-memory window.
REQ-008 ack[0:PROC_CNT-1]  out  1 each  registered; set equal to the grant-time trigger value on retirement.
REQ-009 ptr_out[0:PROC_CNT-1]  out  SIZE each  allocated pointer returned by a WRITE.
REQ-010 err[0:PROC_CNT-1]  out  1 each  sticky; set on an invalid action or a timeout.
REQ-011 req_valid, req_proc ($clog2(PROC_CNT)), req_action (2), req_ptr (SIZE), req_copy_start, req_copy_length (PROCSIZE)  out  command to the DMA engine.
REQ-012 req_ready  in  1  engine accepts the command.
REQ-013 eng_done  in  1  one-cycle completion pulse from the engine.
REQ-014 eng_ptr  in  SIZE  result pointer, valid with eng_done.
REQ-015 busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 The block SHALL use a state machine with states IDLE, ISSUE and BUSY.
REQ-017 IDLE: the grant SHALL go to the first pending index at or after rr_ptr, searching upward modulo PROC_CNT.
REQ-018 On grant, the block SHALL latch the granted index g, trigger[g], action[g], ptr[g], copy_start[g] and copy_length[g].
REQ-019 After a valid-action grant the state SHALL be ISSUE on the next cycle.
REQ-020 A grant with action 3 SHALL NOT issue a command. On the next cycle it SHALL set err[g], set ack[g] to the latched trigger and set rr_ptr to (g+1) mod PROC_CNT, and the state SHALL remain IDLE.
REQ-021 ISSUE: req_valid SHALL be 1, and all req_* fields SHALL come from the latched registers and stay stable until acceptance.
REQ-022 In ISSUE, req_ready=1 SHALL complete the handshake in that cycle; the next state SHALL be BUSY and req_valid SHALL be 0 on the following cycle.
REQ-023 ISSUE SHALL have no timeout.
REQ-024 BUSY: the watchdog counter SHALL be cleared on entry and incremented every cycle.
REQ-025 eng_done in BUSY SHALL retire the request: ack[g] SHALL be set to the latched trigger, rr_ptr SHALL become (g+1) mod PROC_CNT and the state SHALL return to IDLE.
REQ-026 On retirement, ptr_out[g] SHALL be updated to eng_ptr only when the latched action is WRITE; otherwise it SHALL be unchanged.
REQ-027 If the watchdog reaches TIMEOUT-1 without eng_done, the request SHALL be retired as in REQ-025 (without a ptr_out update) and err[g] SHALL be set.
REQ-028 eng_done outside BUSY SHALL be ignored.
REQ-029 Retirement SHALL use the latched trigger value, so a trigger[g] toggle during service stays pending afterwards.
REQ-030 Request inputs for a granted processor SHALL be ignored after grant until retirement.
REQ-031 Throughput SHALL be at most one grant per retirement, with a minimum of 1 cycle from retirement to the next ISSUE.

Reset
REQ-032 While reset_n=0 at a clock edge: state=IDLE, rr_ptr=0, req_valid=0, busy=0, watchdog=0, all ack=0, all err=0, all ptr_out=0, and all req_* fields=0.
REQ-033 Reset asserted mid-operation SHALL abandon the in-flight command without any ack change; req_valid SHALL be 0 on the cycle after the reset edge.
REQ-034 After reset, any trigger already at 1 SHALL be treated as pending.

Verification
REQ-035 Single WRITE: proc 1 toggles trigger, ptr=0, engine ready at once, eng_done after 5 cycles with eng_ptr=4 -> ptr_out[1]=4, ack[1]=1, err=0, busy falls.
REQ-036 Fairness: all 4 procs pending with READ -> grant order 0,1,2,3, then proc 0 re-toggles -> next grant 0; no processor is granted twice while another is pending.
REQ-037 Backpressure: req_ready held 0 for 10 cycles -> req_valid and all req_* fields stay constant, no timeout; accepted when req_ready=1.
REQ-038 Timeout: TIMEOUT=8, no eng_done -> retired 8 cycles after entering BUSY, err[g]=1, ack toggled, ptr_out unchanged.
REQ-039 Invalid action 3 on proc 2 -> err[2]=1, ack[2] toggled, req_valid never asserted.
REQ-040 Reset while in BUSY, then eng_done pulse -> ack unchanged, state IDLE, pulse ignored; proc re-granted since still pending.
